reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2: number of synchroniser flops on the reset-deassertion path; legal >= 2.
REQ-002 The module SHALL have parameter NUM_OUT, default 4: number of sequenced reset outputs; legal >= 1.
REQ-003 The module SHALL have parameter MIN_ASSERT, default 8: minimum cycles all outputs stay asserted after a synchronised release or a software request; legal >= 1.
REQ-004 The module SHALL have parameter STAGGER, default 16: cycles between successive output releases; legal >= 1.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The module SHALL have port ext_reset, input, 1 bit: asynchronous, active-low external reset.
REQ-007 The module SHALL have port sw_reset_req, input, 1 bit: synchronous, active-high software reset request, sampled on clk rising edges.
REQ-008 The module SHALL have port resetn_out, output, NUM_OUT bits: active-low reset to domain k (bit k), registered.
REQ-009 The module SHALL have port seq_done, output, 1 bit: high when all outputs are released.

Function
REQ-010 ext_reset low SHALL asynchronously, with no clock edge: clear the sync chain; force resetn_out to all 0; set seq_done 0; set FSM to SYNC; clear counters.
REQ-011 After ext_reset rises, the sync chain SHALL shift in 1 per edge; sync_ok (last stage) SHALL go high on rising edge SYNC_STAGES (edge 1 = first edge after deassertion).
REQ-012 FSM states SHALL be SYNC, STRETCH, RELEASE and DONE.
REQ-013 SYNC SHALL move to STRETCH, with cnt=0, on the first edge on which sync_ok is 1 (edge SYNC_STAGES+1).
REQ-014 In STRETCH on each edge: if cnt==MIN_ASSERT-1, the FSM SHALL set resetn_out[0]=1, set idx=1 and cnt=0, and enter RELEASE; otherwise it SHALL increment cnt.
REQ-015 In RELEASE on each edge: if cnt==STAGGER-1, the FSM SHALL set resetn_out[idx]=1 and cnt=0 and increment idx; otherwise it SHALL increment cnt.
REQ-016 The FSM SHALL enter DONE and set seq_done=1 on the same edge that releases bit NUM_OUT-1; if NUM_OUT==1, this is the STRETCH-exit edge.
REQ-017 Release timing from ext_reset deassertion SHALL be: bit k released at edge SYNC_STAGES+1+MIN_ASSERT+k*STAGGER.
REQ-018 Once a bit is released, it SHALL stay 1 until the next ext_reset or sw_reset_req.
REQ-019 sw_reset_req=1 on an edge in STRETCH, RELEASE or DONE SHALL, on that edge: set resetn_out to all 0; set seq_done 0; set cnt=0 and idx=0; and enter STRETCH.
REQ-020 sw_reset_req held high SHALL keep cnt at 0 each edge; if the last high sample is at edge E, bit k SHALL be released at edge E+MIN_ASSERT+k*STAGGER.
REQ-021 sw_reset_req SHALL be ignored in SYNC.
REQ-022 sw_reset_req SHALL win over a release scheduled on the same edge.
REQ-023 The counter SHALL be wide enough for max(MIN_ASSERT,STAGGER)-1 and SHALL never wrap.
REQ-024 idx SHALL be wide enough for NUM_OUT.
REQ-025 All outputs SHALL come directly from flops, with no combinational path from any input to any output.

Reset
REQ-026 The reset values SHALL be: resetn_out all 0, seq_done 0, sync chain all 0, FSM SYNC, cnt 0, idx 0.
REQ-027 Reset assertion SHALL be asynchronous; deassertion SHALL take effect only through the SYNC_STAGES synchroniser.
REQ-028 ext_reset low mid-sequence (any state) SHALL immediately restore all reset values.

Verification
REQ-029 Defaults; ext_reset released; count edges -> resetn_out bits 0..3 rise at edges 11, 27, 43, 59; seq_done rises at edge 59; no bit changes before its edge.
REQ-030 Defaults, in DONE; sw_reset_req high for 1 cycle at edge E -> resetn_out=4'b0000 and seq_done=0 at edge E; bit 0 rises at E+8, bit 3 at E+56.
REQ-031 Defaults; ext_reset pulsed low between clk edges during RELEASE (after bit 1 is released) -> resetn_out=0 and seq_done=0 before the next edge; full sequence restarts per REQ-017.
REQ-032 Defaults; sw_reset_req held high for 5 cycles, last high at edge E -> all outputs held at 0 throughout; bit 0 rises at E+8.
REQ-033 NUM_OUT=1, SYNC_STAGES=3, MIN_ASSERT=1, STAGGER=1 -> resetn_out[0] and seq_done rise together at edge 5.
REQ-034 Defaults; sw_reset_req=1 exactly on edge 27 (the scheduled bit-1 release) -> bit 1 stays 0; all outputs 0; bit 0 rises at edge 35.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset sequencer.
// The external reset is asserted asynchronously and released through a
// synchroniser. All outputs are held in reset for MIN_ASSERT cycles, then
// released one per STAGGER cycles, lowest index first. A software request
// restarts the stretch/release sequence without involving the synchroniser.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 4,
  parameter int MIN_ASSERT  = 8,
  parameter int STAGGER     = 16
) (
  input  logic               clk,
  input  logic               ext_reset,
  input  logic               sw_reset_req,
  output logic [NUM_OUT-1:0] resetn_out,
  output logic               seq_done
);

  localparam int CNT_MAX = (MIN_ASSERT > STAGGER) ? MIN_ASSERT : STAGGER;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_OUT + 1);

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                   state, state_nxt;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     sync_ok;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [IDX_W-1:0]         idx, idx_nxt;
  logic [NUM_OUT-1:0]       resetn_nxt;
  logic                     seq_done_nxt;

  assign sync_ok = sync_q[SYNC_STAGES-1];

  // Synchroniser: cleared at once by ext_reset, fills with ones afterwards.
  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) sync_q <= '0;
    else            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) begin
      state      <= ST_SYNC;
      cnt        <= '0;
      idx        <= '0;
      resetn_out <= '0;
      seq_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      resetn_out <= resetn_nxt;
      seq_done   <= seq_done_nxt;
    end
  end

  // Next-state decision; a software request outranks any scheduled release.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SYNC: begin
        if (sync_ok) state_nxt = ST_STRETCH;
      end
      ST_STRETCH: begin
        if (sw_reset_req)          state_nxt = ST_STRETCH;
        else if (cnt == MIN_LAST)  state_nxt = (NUM_OUT == 1) ? ST_DONE : ST_RELEASE;
      end
      ST_RELEASE: begin
        if (sw_reset_req)                            state_nxt = ST_STRETCH;
        else if (cnt == STG_LAST && idx == IDX_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (sw_reset_req) state_nxt = ST_STRETCH;
      end
      default: state_nxt = ST_SYNC;
    endcase
  end

  // Next values of counters and outputs; released bits hold until a restart.
  always_comb begin
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    resetn_nxt   = resetn_out;
    seq_done_nxt = seq_done;
    case (state)
      ST_SYNC: begin
        cnt_nxt = '0;
        idx_nxt = '0;
      end
      ST_STRETCH: begin
        if (sw_reset_req) begin
          cnt_nxt      = '0;
          idx_nxt      = '0;
          resetn_nxt   = '0;
          seq_done_nxt = 1'b0;
        end else if (cnt == MIN_LAST) begin
          cnt_nxt       = '0;
          idx_nxt       = IDX_W'(1);
          resetn_nxt[0] = 1'b1;
          if (NUM_OUT == 1) seq_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (sw_reset_req) begin
          cnt_nxt      = '0;
          idx_nxt      = '0;
          resetn_nxt   = '0;
          seq_done_nxt = 1'b0;
        end else if (cnt == STG_LAST) begin
          cnt_nxt = '0;
          idx_nxt = idx + IDX_W'(1);
          for (int k = 0; k < NUM_OUT; k++) begin
            if (idx == IDX_W'(k)) resetn_nxt[k] = 1'b1;
          end
          if (idx == IDX_LAST) seq_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (sw_reset_req) begin
          cnt_nxt      = '0;
          idx_nxt      = '0;
          resetn_nxt   = '0;
          seq_done_nxt = 1'b0;
        end
      end
      default: begin
        cnt_nxt      = '0;
        idx_nxt      = '0;
        resetn_nxt   = '0;
        seq_done_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default instance and a minimal one
// (NUM_OUT=1, SYNC_STAGES=3, MIN_ASSERT=1, STAGGER=1) share all inputs and
// are compared every cycle against a schedule model: bit k is released at
// edge anchor+MIN_ASSERT+k*STAGGER, where the anchor is edge SYNC_STAGES+1
// after ext_reset release, moved to the edge of any effective sw request.
module tb_reset_sequencer;

  localparam int S1 = 2, N1 = 4, M1 = 8,  G1 = 16;
  localparam int S2 = 3, N2 = 1, M2 = 1,  G2 = 1;

  logic          clk = 1'b0;
  logic          ext_reset;
  logic          sw_reset_req;
  logic [N1-1:0] resetn_a;
  logic          done_a;
  logic [N2-1:0] resetn_b;
  logic          done_b;

  int checks   = 0;
  int failures = 0;
  int n        = 0;       // edges since ext_reset release (0 while held)
  int anchor_a = S1 + 1;
  int anchor_b = S2 + 1;

  always #5 clk = ~clk;

  reset_sequencer #(.SYNC_STAGES(S1), .NUM_OUT(N1), .MIN_ASSERT(M1), .STAGGER(G1)) dut_a (
    .clk(clk), .ext_reset(ext_reset), .sw_reset_req(sw_reset_req),
    .resetn_out(resetn_a), .seq_done(done_a));

  reset_sequencer #(.SYNC_STAGES(S2), .NUM_OUT(N2), .MIN_ASSERT(M2), .STAGGER(G2)) dut_b (
    .clk(clk), .ext_reset(ext_reset), .sw_reset_req(sw_reset_req),
    .resetn_out(resetn_b), .seq_done(done_b));

  function automatic logic [31:0] exp_bits(int edge_n, int anchor, int min_a, int stag, int num);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < num; k++)
      if (edge_n >= anchor + min_a + k * stag) r[k] = 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, n, obs, expv);
    end
  endtask

  task automatic check_all();
    logic [31:0] ea, eb;
    ea = exp_bits(n, anchor_a, M1, G1, N1);
    eb = exp_bits(n, anchor_b, M2, G2, N2);
    check("resetn_a", 32'(resetn_a), ea);
    check("done_a",   32'(done_a),   32'(ea[N1-1]));
    check("resetn_b", 32'(resetn_b), eb);
    check("done_b",   32'(done_b),   32'(eb[N2-1]));
  endtask

  // One clock cycle with the given request level; checked at the falling edge.
  task automatic tick(input logic sw);
    sw_reset_req = sw;
    @(posedge clk);
    if (ext_reset) begin
      n++;
      if (sw && n >= S1 + 2) anchor_a = n;
      if (sw && n >= S2 + 2) anchor_b = n;
    end
    @(negedge clk);
    check_all();
  endtask

  // Short ext_reset pulse between edges; outputs must clear without a clock.
  task automatic async_pulse();
    ext_reset = 1'b0;
    #1;
    n        = 0;
    anchor_a = S1 + 1;
    anchor_b = S2 + 1;
    check_all();
    #1;
    ext_reset = 1'b1;
  endtask

  initial begin
    ext_reset    = 1'b0;
    sw_reset_req = 1'b0;
    #1;
    check_all();                          // reset values with no edge yet
    @(negedge clk);
    repeat (3) tick(1'b1);                // held in reset, request ignored

    // Power-on sequence: bits at 11/27/43/59, minimal instance at 5.
    ext_reset = 1'b1;
    repeat (70) tick(1'b0);

    // Single-cycle request in DONE.
    tick(1'b1);
    repeat (60) tick(1'b0);

    // Request held for 5 cycles.
    repeat (5) tick(1'b1);
    repeat (60) tick(1'b0);

    // Fresh sequence, request exactly on the bit-1 release edge (27).
    async_pulse();
    repeat (26) tick(1'b0);
    tick(1'b1);
    repeat (40) tick(1'b0);

    // Asynchronous reset during RELEASE with bits 0..2 released.
    async_pulse();
    repeat (70) tick(1'b0);

    // Randomised requests and occasional async resets.
    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r == 0) async_pulse();
      else if (r < 8) repeat (int'($urandom_range(1, 4))) tick(1'b1);
      else tick(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
